// File: rtl/reg_write_queue_pkg.sv
// Shared widths and entry type for the register write queue.
package reg_write_queue_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wq_entry_t;

endpackage

// File: rtl/reg_write_queue_bypass_match.sv
// Youngest-match search over the queue entries for one decode read port.
// With REG_WRITE_QUEUE_X0_FILTER_EN defined, address 0 never hits.
module wq_bypass_match
   import reg_write_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wq_entry_t [DEPTH-1:0]         entries,
   input  logic [$clog2(DEPTH)-1:0]      wr_ptr,
   input  logic [REG_ADDR_W-1:0]         addr,
   output logic                          hit,
   output logic [REG_DATA_W-1:0]         data
);

   localparam int PTR_W = $clog2(DEPTH);

   // Walk oldest to youngest starting at wr_ptr so the last match wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx  = '0;
      hit  = 1'b0;
      data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = wr_ptr + PTR_W'(k);
         if (entries[idx].valid && (entries[idx].addr == addr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
`ifdef REG_WRITE_QUEUE_X0_FILTER_EN
      if (addr == '0) begin
         hit  = 1'b0;
         data = '0;
      end
`endif
   end

endmodule

// File: rtl/reg_write_queue.sv
// In-order register writeback queue with youngest-match decode bypass.
// Optional REG_WRITE_QUEUE_X0_FILTER_EN drops writes to register 0.
module reg_write_queue
   import reg_write_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     hold,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        a3,
   output logic [DATA_W-1:0]        wr_data,
   input  logic [ADDR_W-1:0]        a1,
   input  logic [ADDR_W-1:0]        a2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [DATA_W-1:0]        byp_data1,
   output logic [DATA_W-1:0]        byp_data2,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [DEPTH-1:0]  vld;
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   wq_entry_t [DEPTH-1:0] entries;
   logic push;
   logic pop;

   assign in_ready = (level < LVL_W'(DEPTH));
   assign wr_en    = (level != '0) && !hold;
   assign pop      = wr_en;
   assign a3       = mem_addr[rd_ptr];
   assign wr_data  = mem_data[rd_ptr];

`ifdef REG_WRITE_QUEUE_X0_FILTER_EN
   // Register-0 writes are accepted but never allocated.
   assign push = in_valid && in_ready && (in_addr != '0);
`else
   assign push = in_valid && in_ready;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         vld    <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Payload storage is deliberately not reset; vld gates every use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= in_addr;
         mem_data[wr_ptr] <= in_data;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries[i].valid = vld[i];
         entries[i].addr  = mem_addr[i];
         entries[i].data  = mem_data[i];
      end
   end

   wq_bypass_match #(.DEPTH(DEPTH)) u_match1 (
      .entries (entries),
      .wr_ptr  (wr_ptr),
      .addr    (a1),
      .hit     (hit1),
      .data    (byp_data1)
   );

   wq_bypass_match #(.DEPTH(DEPTH)) u_match2 (
      .entries (entries),
      .wr_ptr  (wr_ptr),
      .addr    (a2),
      .hit     (hit2),
      .data    (byp_data2)
   );

endmodule
